// File: rtl/n64adv_rst_seq_multi.sv
// Multi-channel reset sequencer: lock qualification, staggered release,
// per-channel recovery after lock loss and global re-hold on config change.
// Ports: CLK/nRST (sync, active-low); CLK_EN_i per-channel lock (async);
//        REQ_i per-channel run request; CFG_i config word (async);
//        nRST_o per-channel resets; READY_o all requested channels up;
//        HOLD_ACTIVE_o sequencer not in ST_RUN.
module n64adv_rst_seq_multi #(
    parameter int NCH         = 4,
    parameter int CFG_W       = 2,
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_W      = 4,
    parameter int HOLD_LEN    = 15,
    parameter int SEQ_DELAY   = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [NCH-1:0]   CLK_EN_i,
    input  logic [NCH-1:0]   REQ_i,
    input  logic [CFG_W-1:0] CFG_i,
    output logic [NCH-1:0]   nRST_o,
    output logic             READY_o,
    output logic             HOLD_ACTIVE_o
);

    localparam int IDX_W = $clog2(NCH + 1);
    localparam int GAP_W = $clog2(SEQ_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_V = HOLD_W'(HOLD_LEN);
    localparam logic [GAP_W-1:0]  GAP_V  = GAP_W'(SEQ_DELAY - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_SEQ,
        ST_RUN
    } state_t;

    logic [SYNC_STAGES-1:0][NCH-1:0]   en_sync;
    logic [SYNC_STAGES-1:0][CFG_W-1:0] cfg_sync;
    logic [CFG_W-1:0] cfg_d;
    logic [NCH-1:0]   lock_s;
    logic [CFG_W-1:0] cfg_s;
    logic [NCH-1:0]   run_req;
    logic             cfg_chg;

    state_t st, st_n;
    logic [HOLD_W-1:0] hcnt, hcnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [GAP_W-1:0]  gap, gap_n;
    logic [NCH-1:0]    armed, armed_n;
    logic [NCH-1:0][HOLD_W-1:0] chold, chold_n;
    logic [NCH-1:0]    nrst_n;
    logic              ready_n;

    assign lock_s  = en_sync[SYNC_STAGES-1];
    assign cfg_s   = cfg_sync[SYNC_STAGES-1];
    assign run_req = REQ_i & lock_s;
    assign cfg_chg = (cfg_s != cfg_d);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            en_sync       <= '0;
            cfg_sync      <= '0;
            cfg_d         <= '0;
            st            <= ST_HOLD;
            hcnt          <= HOLD_V;
            idx           <= '0;
            gap           <= '0;
            armed         <= '0;
            chold         <= '0;
            nRST_o        <= '0;
            READY_o       <= 1'b0;
            HOLD_ACTIVE_o <= 1'b1;
        end else begin
            en_sync       <= {en_sync[SYNC_STAGES-2:0], CLK_EN_i};
            cfg_sync      <= {cfg_sync[SYNC_STAGES-2:0], CFG_i};
            cfg_d         <= cfg_s;
            st            <= st_n;
            hcnt          <= hcnt_n;
            idx           <= idx_n;
            gap           <= gap_n;
            armed         <= armed_n;
            chold         <= chold_n;
            nRST_o        <= nrst_n;
            READY_o       <= ready_n;
            HOLD_ACTIVE_o <= (st_n != ST_RUN);
        end
    end

    always_comb begin
        st_n    = st;
        hcnt_n  = hcnt;
        idx_n   = idx;
        gap_n   = gap;
        armed_n = armed;
        chold_n = chold;
        nrst_n  = '0;

        if (cfg_chg) begin
            st_n    = ST_HOLD;
            hcnt_n  = HOLD_V;
            idx_n   = '0;
            gap_n   = '0;
            armed_n = '0;
            chold_n = '0;
        end else begin
            unique case (st)
                ST_HOLD: begin
                    hcnt_n = hcnt - 1'b1;
                    if (hcnt == HOLD_W'(1)) begin
                        st_n  = ST_SEQ;
                        idx_n = '0;
                        gap_n = '0;
                    end
                end
                ST_SEQ, ST_RUN: begin
                    // Recovery of channels already handed over by the sequencer
                    for (int i = 0; i < NCH; i++) begin
                        if (armed[i]) begin
                            if (!run_req[i]) begin
                                chold_n[i] = HOLD_V;
                            end else if (chold[i] != '0) begin
                                chold_n[i] = chold[i] - 1'b1;
                            end else begin
                                nrst_n[i] = 1'b1;
                            end
                        end
                    end
                    if (st == ST_SEQ) begin
                        if (gap != '0) begin
                            gap_n = gap - 1'b1;
                        end else if (idx == IDX_W'(NCH)) begin
                            st_n = ST_RUN;
                        end else begin
                            for (int i = 0; i < NCH; i++) begin
                                if (idx == IDX_W'(i)) begin
                                    armed_n[i] = 1'b1;
                                    if (run_req[i]) begin
                                        nrst_n[i]  = 1'b1;
                                        chold_n[i] = '0;
                                        gap_n      = GAP_V;
                                    end else begin
                                        // skipped channel joins recovery path
                                        chold_n[i] = HOLD_V;
                                    end
                                end
                            end
                            idx_n = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    st_n = ST_HOLD;
                end
            endcase
        end
    end

    // "Requested" means REQ_i, so a channel that lost lock drops READY_o
    always_comb begin
        ready_n = 1'b0;
        if (!cfg_chg && st == ST_RUN)
            ready_n = &(nRST_o | ~REQ_i);
    end

endmodule

// File: tb/tb_n64adv_rst_seq_multi.sv
// Scoreboard bench for n64adv_rst_seq_multi: timed expectations are queued
// by the stimulus and checked by a negedge monitor against an edge counter.
module tb_n64adv_rst_seq_multi;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [3:0] CLK_EN_i = 4'hF;
    logic [3:0] REQ_i = 4'hF;
    logic [1:0] CFG_i = 2'd0;
    logic [3:0] nRST_o;
    logic       READY_o;
    logic       HOLD_ACTIVE_o;

    n64adv_rst_seq_multi dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .CLK_EN_i     (CLK_EN_i),
        .REQ_i        (REQ_i),
        .CFG_i        (CFG_i),
        .nRST_o       (nRST_o),
        .READY_o      (READY_o),
        .HOLD_ACTIVE_o(HOLD_ACTIVE_o)
    );

    always #5 CLK = ~CLK;

    int ecnt = 0;
    always @(posedge CLK) ecnt <= ecnt + 1;

    typedef struct {
        int         t;
        string      nm;
        logic [3:0] m;
        logic [3:0] n;
        int         r;
        int         h;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   base;

    task automatic ex(input int t, input string nm, input logic [3:0] m,
                      input logic [3:0] n, input int r, input int h);
        exp_t e;
        e.t = t; e.nm = nm; e.m = m; e.n = n; e.r = r; e.h = h;
        sb.push_back(e);
    endtask

    task automatic wait_edge(input int t);
        while (ecnt < t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        base = ecnt;
        nRST = 1'b1;
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].t <= ecnt) begin
            exp_t e;
            bit   ok;
            e = sb.pop_front();
            n_chk++;
            ok = (e.t == ecnt) && ((nRST_o & e.m) == (e.n & e.m));
            if (e.r >= 0 && READY_o !== e.r[0]) ok = 0;
            if (e.h >= 0 && HOLD_ACTIVE_o !== e.h[0]) ok = 0;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s edge=%0d(want %0d) nRST_o=%b want %b/%b rdy=%b want %0d hold=%b want %0d",
                         e.nm, ecnt, e.t, nRST_o, e.n, e.m, READY_o, e.r,
                         HOLD_ACTIVE_o, e.h);
            end
        end
    end

    initial begin
        int b, b2, b4;
        do_reset();
        b = base;
        ex(b,      "rst_state", 4'hF, 4'h0, 0, 1);
        ex(b + 15, "hold_end",  4'hF, 4'h0, 0, 1);
        ex(b + 16, "ch0_up",    4'hF, 4'h1, 0, 1);
        ex(b + 23, "ch1_pre",   4'hF, 4'h1, -1, 1);
        ex(b + 24, "ch1_up",    4'hF, 4'h3, -1, 1);
        ex(b + 32, "ch2_up",    4'hF, 4'h7, -1, 1);
        ex(b + 40, "ch3_up",    4'hF, 4'hF, 0, 1);
        ex(b + 47, "seq_tail",  4'hF, 4'hF, 0, 1);
        ex(b + 48, "run_hold",  4'hF, 4'hF, 0, 0);
        ex(b + 49, "ready",     4'hF, 4'hF, 1, 0);
        ex(b + 103, "lock_pre", 4'hF, 4'hF, 1, 0);
        ex(b + 104, "lock_low", 4'hF, 4'hD, 1, 0);
        ex(b + 105, "lock_rdy", 4'hF, 4'hD, 0, 0);
        ex(b + 138, "rec_pre",  4'hF, 4'hD, 0, 0);
        ex(b + 139, "rec_up",   4'hF, 4'hF, 0, 0);
        ex(b + 140, "rec_rdy",  4'hF, 4'hF, 1, 0);
        wait_edge(b + 100);
        CLK_EN_i = 4'b1101;
        wait_edge(b + 120);
        CLK_EN_i = 4'hF;
        wait_edge(b + 160);

        do_reset();
        b2 = base;
        ex(b2,      "pulse_rst", 4'hF, 4'h0, 0, 1);
        ex(b2 + 16, "p_ch0",     4'hF, 4'h1, 0, 1);
        ex(b2 + 24, "p_ch1",     4'hF, 4'h3, 0, 1);
        ex(b2 + 40, "p_ch3",     4'hF, 4'hF, 0, 1);
        ex(b2 + 48, "p_run",     4'hF, 4'hF, 0, 0);
        ex(b2 + 49, "p_ready",   4'hF, 4'hF, 1, 0);
        ex(b2 + 103, "cfg_pre",  4'hF, 4'hF, 1, 0);
        ex(b2 + 104, "cfg_low",  4'hF, 4'h0, 0, 1);
        ex(b2 + 119, "cfg_hold", 4'hF, 4'h0, 0, 1);
        ex(b2 + 120, "cfg_ch0",  4'hF, 4'h1, 0, 1);
        ex(b2 + 128, "cfg_ch1",  4'hF, 4'h3, 0, 1);
        ex(b2 + 133, "seqc_pre", 4'hF, 4'h3, 0, 1);
        ex(b2 + 134, "seqc_low", 4'hF, 4'h0, 0, 1);
        ex(b2 + 149, "seqc_hld", 4'hF, 4'h0, 0, 1);
        ex(b2 + 150, "seqc_ch0", 4'hF, 4'h1, 0, 1);
        ex(b2 + 158, "seqc_ch1", 4'hF, 4'h3, 0, 1);
        ex(b2 + 174, "seqc_ch3", 4'hF, 4'hF, 0, 1);
        ex(b2 + 181, "seqc_tl",  4'hF, 4'hF, 0, 1);
        ex(b2 + 182, "seqc_run", 4'hF, 4'hF, 0, 0);
        ex(b2 + 183, "seqc_rdy", 4'hF, 4'hF, 1, 0);
        wait_edge(b2 + 100);
        CFG_i = 2'd2;
        wait_edge(b2 + 130);
        CFG_i = 2'd1;
        wait_edge(b2 + 190);

        CFG_i = 2'd0;
        REQ_i = 4'b1011;
        do_reset();
        b4 = base;
        ex(b4,      "skip_rst",  4'hF, 4'h0, 0, 1);
        ex(b4 + 16, "skip_ch0",  4'hF, 4'h1, 0, 1);
        ex(b4 + 24, "skip_ch1",  4'hF, 4'h3, 0, 1);
        ex(b4 + 32, "skip_ch2",  4'hF, 4'h3, 0, 1);
        ex(b4 + 33, "skip_ch3",  4'hF, 4'hB, 0, 1);
        ex(b4 + 40, "skip_tail", 4'hF, 4'hB, 0, 1);
        ex(b4 + 41, "skip_run",  4'hF, 4'hB, 0, 0);
        ex(b4 + 42, "skip_rdy",  4'hF, 4'hB, 1, 0);
        ex(b4 + 60, "skip_hold", 4'hF, 4'hB, 1, 0);
        wait_edge(b4 + 65);

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain left=%0d want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog edge=%0d want finish", ecnt);
        $fatal(1, "timeout");
    end

endmodule
